// File: rtl/multi_button_edge_ctrl.sv
// ---------------------------------------------------------------------------
// multi_button_edge_ctrl
//
// N-channel push-button front end. Each raw button input passes through a
// multi-flop synchroniser and a per-channel debouncer. Accepted level changes
// are qualified against a run-time edge mode into one-cycle strobes. The
// strobes drive per-channel LEDs and a shared saturating event counter.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rstb        asynchronous reset, active high, clears all state
//   btn_in      raw asynchronous button levels, 1 = pressed
//   edge_mode   00 rising, 01 falling, 10 both, 11 edges disabled
//   led_mode    0 = LED toggles on qualified edge, 1 = LED mirrors level
//   cnt_clr     synchronous clear of evt_count (wins over new edges)
//   btn_level   debounced level per channel
//   edge_pulse  one-cycle qualified-edge strobe per channel
//   any_edge    OR of edge_pulse, registered alongside it
//   led         per-channel LED drive
//   evt_count   saturating count of qualified edges
// ---------------------------------------------------------------------------
module multi_button_edge_ctrl #(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [N_CH-1:0]  btn_in,
    input  logic [1:0]       edge_mode,
    input  logic             led_mode,
    input  logic             cnt_clr,
    output logic [N_CH-1:0]  btn_level,
    output logic [N_CH-1:0]  edge_pulse,
    output logic             any_edge,
    output logic [N_CH-1:0]  led,
    output logic [CNT_W-1:0] evt_count
);

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Popcount of the strobes and a sum wide enough to never overflow before
    // the saturation compare.
    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    edge_mode_e mode;
    assign mode = edge_mode_e'(edge_mode);

    // -----------------------------------------------------------------------
    // Input synchroniser: sync_q[0] is the metastability-catching stage,
    // the last stage is the clean level seen by the debouncer.
    // -----------------------------------------------------------------------
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_lvl;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true shift chain.
    // NOTE: these small register arrays are reset explicitly; unlike a RAM
    // they must come out of reset at a known value so no phantom edge appears.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= btn_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [DB_W-1:0]  db_cnt_q [N_CH];
    logic [DB_W-1:0]  db_cnt_d [N_CH];
    logic [N_CH-1:0]  level_q, level_d;
    logic [N_CH-1:0]  pulse_q, pulse_d;
    logic [N_CH-1:0]  led_q,   led_d;
    logic             any_q,   any_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // -----------------------------------------------------------------------
    // Debounce and edge qualification
    // A channel counts consecutive cycles where the synchronised level
    // disagrees with the accepted level; any agreement restarts the count.
    // The change is accepted on the cycle the count reaches its last value.
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            db_cnt_d[ch] = '0;
            if (sync_lvl[ch] != level_q[ch]) begin
                if (db_cnt_q[ch] == DB_LAST) begin
                    level_d[ch] = sync_lvl[ch];
                    // New level 1 means a press (rising), 0 a release.
                    case (mode)
                        EDGE_RISE: pulse_d[ch] = sync_lvl[ch];
                        EDGE_FALL: pulse_d[ch] = ~sync_lvl[ch];
                        EDGE_BOTH: pulse_d[ch] = 1'b1;
                        default:   pulse_d[ch] = 1'b0;
                    endcase
                end else begin
                    db_cnt_d[ch] = db_cnt_q[ch] + DB_W'(1);
                end
            end
        end
        any_d = |pulse_d;
    end

    // -----------------------------------------------------------------------
    // LED drive: mirror mode follows the next debounced level so it lines up
    // with btn_level; toggle mode flips from whatever value the LED holds,
    // so leaving mirror mode carries the current LED state forward.
    // -----------------------------------------------------------------------
    always_comb begin
        if (led_mode) begin
            led_d = level_d;
        end else begin
            led_d = led_q ^ pulse_d;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating event counter; simultaneous strobes add in one cycle and a
    // clear request discards that cycle's strobes.
    // -----------------------------------------------------------------------
    logic [PC_W-1:0]  pulse_cnt;
    logic [SUM_W-1:0] cnt_sum;

    always_comb begin
        pulse_cnt = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            pulse_cnt = pulse_cnt + PC_W'(pulse_d[ch]);
        end
        cnt_sum = SUM_W'(cnt_q) + SUM_W'(pulse_cnt);
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_sum > SUM_W'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                db_cnt_q[ch] <= '0;
            end
            level_q <= '0;
            pulse_q <= '0;
            led_q   <= '0;
            any_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                db_cnt_q[ch] <= db_cnt_d[ch];
            end
            level_q <= level_d;
            pulse_q <= pulse_d;
            led_q   <= led_d;
            any_q   <= any_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level  = level_q;
    assign edge_pulse = pulse_q;
    assign any_edge   = any_q;
    assign led        = led_q;
    assign evt_count  = cnt_q;

endmodule

// File: tb/tb_multi_button_edge_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_button_edge_ctrl
//
// Self-checking bench for multi_button_edge_ctrl (2 channels, 3-bit counter).
// A behavioural model keeps a history of sampled button values and accepts a
// level change once the last DEBOUNCE_CYCLES synchronised samples all differ
// from the accepted level. Outputs are compared every falling clock edge,
// through directed scenarios followed by a randomised phase.
// ---------------------------------------------------------------------------
module tb_multi_button_edge_ctrl;

    localparam int NC = 2;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rstb;
    logic [NC-1:0] btn_in;
    logic [1:0]    edge_mode;
    logic          led_mode;
    logic          cnt_clr;
    logic [NC-1:0] btn_level;
    logic [NC-1:0] edge_pulse;
    logic          any_edge;
    logic [NC-1:0] led;
    logic [CW-1:0] evt_count;

    int checks = 0;
    int errors = 0;

    multi_button_edge_ctrl #(
        .N_CH(NC), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstb(rstb), .btn_in(btn_in), .edge_mode(edge_mode),
        .led_mode(led_mode), .cnt_clr(cnt_clr), .btn_level(btn_level),
        .edge_pulse(edge_pulse), .any_edge(any_edge), .led(led),
        .evt_count(evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Reference model
    // smp[k] holds btn_in as sampled k+1 rising edges ago, so the level seen
    // by the debouncer j edges back is smp[SS-1+j].
    // -----------------------------------------------------------------------
    logic [NC-1:0] smp [SS+DC];
    logic [NC-1:0] m_level = '0;
    logic [NC-1:0] m_pulse = '0;
    logic [NC-1:0] m_led   = '0;
    logic          m_any   = 1'b0;
    int            m_cnt   = 0;
    logic [NC-1:0] nl;
    bit            flip;
    bit            rise;

    always @(posedge clk or posedge rstb) begin
        if (rstb) begin
            for (int k = 0; k < SS + DC; k++) smp[k] = '0;
            m_level = '0;
            m_pulse = '0;
            m_led   = '0;
            m_any   = 1'b0;
            m_cnt   = 0;
        end else begin
            nl      = m_level;
            m_pulse = '0;
            for (int ch = 0; ch < NC; ch++) begin
                flip = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    if (smp[SS-1+j][ch] == m_level[ch]) flip = 1'b0;
                end
                if (flip) begin
                    nl[ch] = ~m_level[ch];
                    rise   = nl[ch];
                    if (( rise && (edge_mode == 2'b00 || edge_mode == 2'b10)) ||
                        (!rise && (edge_mode == 2'b01 || edge_mode == 2'b10)))
                        m_pulse[ch] = 1'b1;
                end
            end
            m_any = |m_pulse;
            if (led_mode) m_led = nl;
            else          m_led = m_led ^ m_pulse;
            if (cnt_clr) m_cnt = 0;
            else begin
                m_cnt = m_cnt + $countones(m_pulse);
                if (m_cnt > CMAX) m_cnt = CMAX;
            end
            m_level = nl;
            for (int k = SS + DC - 1; k > 0; k--) smp[k] = smp[k-1];
            smp[0] = btn_in;
        end
    end

    // -----------------------------------------------------------------------
    // Checking helpers
    // -----------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("level", 32'(btn_level),  32'(m_level));
        check("pulse", 32'(edge_pulse), 32'(m_pulse));
        check("any",   32'(any_edge),   32'(m_any));
        check("led",   32'(led),        32'(m_led));
        check("count", 32'(evt_count),  32'(m_cnt));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level"}, 32'(btn_level),  32'd0);
        check({tag, "_pulse"}, 32'(edge_pulse), 32'd0);
        check({tag, "_any"},   32'(any_edge),   32'd0);
        check({tag, "_led"},   32'(led),        32'd0);
        check({tag, "_count"}, 32'(evt_count),  32'd0);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_count();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic press_release(input logic [NC-1:0] pat);
        btn_in = pat;
        ticks(8);
        btn_in = '0;
        ticks(8);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rstb      = 1'b1;
        btn_in    = '0;
        edge_mode = 2'b00;
        led_mode  = 1'b0;
        cnt_clr   = 1'b0;
        ticks(2);
        check_zero("reset");
        rstb = 1'b0;

        // Clean press: strobe lands on the 6th edge after sampling.
        btn_in = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("lat_early", 32'(edge_pulse), 32'd0);
        end
        tick();
        check("lat_pulse", 32'(edge_pulse), 32'd1);
        check("lat_any",   32'(any_edge),   32'd1);
        check("lat_led",   32'(led),        32'd1);
        check("lat_count", 32'(evt_count),  32'd1);
        tick();
        check("one_cycle", 32'(edge_pulse), 32'd0);
        btn_in = 2'b00;
        ticks(8);
        check("rel_level", 32'(btn_level), 32'd0);
        check("rel_count", 32'(evt_count), 32'd1);

        // Glitch of 3 cycles is rejected, hold of exactly 4 is accepted.
        btn_in = 2'b10;
        ticks(3);
        btn_in = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("glitch_level", 32'(btn_level), 32'd0);
        end
        check("glitch_count", 32'(evt_count), 32'd1);
        btn_in = 2'b10;
        ticks(4);
        btn_in = 2'b00;
        ticks(2);
        check("hold4_level", 32'(btn_level),  32'd2);
        check("hold4_pulse", 32'(edge_pulse), 32'd2);
        check("hold4_count", 32'(evt_count),  32'd2);
        ticks(10);

        // Edge modes: falling, both, disabled.
        edge_mode = 2'b01;
        clear_count();
        btn_in = 2'b01;
        ticks(8);
        check("fall_press_level", 32'(btn_level), 32'd1);
        check("fall_press_count", 32'(evt_count), 32'd0);
        btn_in = 2'b00;
        ticks(8);
        check("fall_count", 32'(evt_count), 32'd1);
        edge_mode = 2'b10;
        clear_count();
        press_release(2'b01);
        check("both_count", 32'(evt_count), 32'd2);
        edge_mode = 2'b11;
        clear_count();
        btn_in = 2'b01;
        ticks(8);
        check("off_level", 32'(btn_level), 32'd1);
        btn_in = 2'b00;
        ticks(8);
        check("off_count", 32'(evt_count), 32'd0);

        // Simultaneous edges add together and saturate.
        edge_mode = 2'b00;
        for (int i = 0; i < 4; i++) press_release(2'b11);
        check("sat_count", 32'(evt_count), 32'(CMAX));
        btn_in = 2'b11;
        ticks(5);
        cnt_clr = 1'b1;
        tick();
        check("clr_pulse", 32'(edge_pulse), 32'd3);
        check("clr_count", 32'(evt_count),  32'd0);
        cnt_clr = 1'b0;
        tick();
        check("clr_after", 32'(evt_count), 32'd0);
        btn_in = 2'b00;
        ticks(8);

        // LED mirror, then back to toggle carrying the LED value forward.
        led_mode = 1'b1;
        tick();
        btn_in = 2'b01;
        ticks(6);
        check("mirror_led", 32'(led), 32'd1);
        led_mode = 1'b0;
        tick();
        btn_in = 2'b00;
        ticks(8);
        check("keep_led", 32'(led), 32'd1);
        btn_in = 2'b01;
        ticks(6);
        check("toggle_led", 32'(led), 32'd0);
        btn_in = 2'b00;
        ticks(8);

        // Reset in the middle of a debounce; held button re-debounces.
        btn_in = 2'b01;
        ticks(4);
        rstb = 1'b1;
        #1;
        check_zero("async");
        ticks(2);
        rstb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_early", 32'(edge_pulse), 32'd0);
        end
        tick();
        check("rst_pulse", 32'(edge_pulse), 32'd1);
        check("rst_count", 32'(evt_count),  32'd1);
        btn_in = 2'b00;
        ticks(8);

        // Randomised phase against the model.
        for (int seg = 0; seg < 400; seg++) begin
            btn_in = NC'($urandom_range(0, (1 << NC) - 1));
            if ($urandom_range(0, 9) == 0) edge_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) led_mode = ~led_mode;
            for (int c = 0; c < int'($urandom_range(1, 7)); c++) begin
                cnt_clr = ($urandom_range(0, 15) == 0);
                tick();
            end
            cnt_clr = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                rstb = 1'b1;
                #1;
                check_zero("rand_rst");
                ticks(2);
                rstb = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_button_edge_ctrl.md
Name: multi_button_edge_ctrl

Overview:
Parametrised N-channel push-button front end for the FPGA board designs. Each raw button input is synchronised, debounced and edge-qualified under a run-time edge mode. Qualified edges drive per-channel LED outputs and a shared saturating event counter. The block replaces the fixed two-button rising-edge detector and sits directly between board pins and the LED and user logic.

Parameters:
N_CH, 2, number of button channels (≥1)
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (≥2)
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a level change (≥1)
CNT_W, 8, width of the shared event counter (≥1)

Ports:
clk  input  1  system clock, all logic on the rising edge
rstb  input  1  asynchronous, active-high reset; asserted = 1 clears all state immediately
btn_in  input  N_CH  raw, asynchronous button levels, 1 = pressed
edge_mode  input  2  00 rising, 01 falling, 10 both, 11 edges disabled
led_mode  input  1  0 = LED toggles on qualified edge, 1 = LED mirrors debounced level
cnt_clr  input  1  synchronous clear of evt_count
btn_level  output  N_CH  debounced level per channel
edge_pulse  output  N_CH  one-cycle qualified-edge strobe per channel
any_edge  output  1  OR of edge_pulse, registered with it
led  output  N_CH  per-channel LED drive
evt_count  output  CNT_W  saturating count of qualified edges

Behaviour:
- Reset (rstb=1, async): synchroniser flops, debounce counters, btn_level, edge_pulse, any_edge, led and evt_count all go to 0. No edge is generated on release of reset.
- Sync: s[i] is btn_in[i] delayed by SYNC_STAGES flops.
- Debounce, per channel:
  - If s[i] == btn_level[i], the counter goes to 0.
  - Otherwise the counter increments. On the edge where the counter equals DEBOUNCE_CYCLES-1, btn_level[i] takes s[i] and the counter goes to 0.
  - Any return of s[i] to btn_level[i] before that edge restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles produce no change.
- Latency: btn_in is held stable from sampling edge E1. btn_level and edge_pulse update on edge E(SYNC_STAGES+DEBOUNCE_CYCLES), which is E6 at default parameters.
- Edge qualification: edge_pulse[i] is registered 1 for exactly one cycle, on the same edge btn_level[i] changes, when all of the following hold:
  - the change is 0→1 and edge_mode is 00 or 10, or
  - the change is 1→0 and edge_mode is 01 or 10.
  - edge_mode 11: edge_pulse never asserts; btn_level still tracks.
  - edge_mode is sampled at the qualifying edge; no latching.
- any_edge: registered OR of the next-state edge_pulse, aligned with edge_pulse.
- LED:
  - led_mode=0: led[i] inverts on the edge where edge_pulse[i] is set.
  - led_mode=1: led[i] equals btn_level[i], same cycle alignment.
  - On switching 1→0, led keeps its current value and toggling resumes from it.
- Event counter:
  - Next value = evt_count + popcount(next edge_pulse), saturating at 2^CNT_W−1 with no wrap.
  - Multiple simultaneous channel edges add together in one cycle.
  - cnt_clr=1 has priority: the counter goes to 0 and edges in that cycle are not counted.
- Reset mid-debounce discards the pending change. After release the block restarts from level 0, so a button still held pressed then debounces as a new rising edge.

Test Plan:
1. Reset then clean press: rstb=1 for 2 cycles, release, btn_in[0] 0→1 held, edge_mode=00, led_mode=0 → edge_pulse[0]=1 for one cycle on edge 6 after sampling; led[0]=1; evt_count=1; release gives no pulse.
2. Glitch rejection: btn_in[1] high for 3 cycles then low → btn_level[1], edge_pulse and evt_count unchanged; a hold of exactly 4 cycles is accepted.
3. Edge modes: press/release ch0 under 01, 10 and 11 → pulses only on the release, on both transitions, and never, respectively. evt_count is 1, 2 and 0 per press/release pair; btn_level tracks in all modes.
4. Simultaneous edges and saturation: CNT_W=3; both channels pressed together repeatedly → +2 per event, holds at 7. Assert cnt_clr in the same cycle as a pulse → evt_count=0.
5. LED modes: led_mode=1 → led follows btn_level. Switch to 0 while led=1, then one press → led=0.
6. Async reset mid-debounce: assert rstb 2 cycles into debounce of a press → all outputs 0 immediately. Release with button held → rising edge after 6 edges, evt_count=1.
